// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the prefetching fetch queue
package fetch_pkg;
    // Decode-facing entry; the fetch queue is 32-bit in this codebase.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    typedef enum logic {
        S_BOOT,
        S_RUN
    } fetchq_state_e;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
endpackage

// File: rtl/fetchq_fifo.sv
// fetchq_fifo: DEPTH-entry in-order buffer of fetched {pc, instr} words
// Ports:
//   clk_i, reset_i   clock, asynchronous active-low reset
//   clr_i            synchronous clear (flush); wins over push/pop
//   push_i, din_i    write one entry (caller never pushes when full)
//   pop_i            drop the head (caller never pops when empty)
//   dout_o           head entry
//   occ_o            number of valid entries, 0..DEPTH
module fetchq_fifo #(
    parameter int  DEPTH = 4,
    parameter type T     = logic [63:0]
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     clr_i,
    input  logic                     push_i,
    input  T                         din_i,
    input  logic                     pop_i,
    output T                         dout_o,
    output logic [$clog2(DEPTH):0]   occ_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int OW = AW + 1;
    T mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ_o  <= '0;
        end else if (clr_i) begin
            wr_ptr <= rd_ptr;
            occ_o  <= '0;
        end else begin
            if (push_i) wr_ptr <= wr_ptr + AW'(1);
            if (pop_i) rd_ptr <= rd_ptr + AW'(1);
            occ_o <= occ_o + OW'(push_i) - OW'(pop_i);
        end
    end
    always_ff @(posedge clk_i) begin
        if (push_i && !clr_i) mem[wr_ptr] <= din_i;
    end
    assign dout_o = mem[rd_ptr];
endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: prefetching instruction-fetch front end with flush and optional bypass
// Optional feature: define FETCHQ_BYPASS_EN to let a response reach decode in the
// same cycle when the queue is empty.
// Ports:
//   clk_i, reset_i                 clock, asynchronous active-low reset
//   iaddr_o, ireq_o, igrant_i      in-order fetch request handshake
//   irvalid_i, irdata_i            in-order fetch responses, at most one per cycle
//   flush_i, flush_pc_i            redirect from EXE; flush_pc_i[1:0] ignored
//   if_valid_o, if_pc_o, if_instr_o, if_ready_i   head entry toward decode
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int              XLEN            = 32,
    parameter int              DEPTH           = 4,
    parameter int              MAX_OUTSTANDING = 2,
    parameter logic [XLEN-1:0] RESET_PC        = '0
) (
    input  logic            clk_i,
    input  logic            reset_i,
    output logic [XLEN-1:0] iaddr_o,
    output logic            ireq_o,
    input  logic            igrant_i,
    input  logic            irvalid_i,
    input  logic [XLEN-1:0] irdata_i,
    input  logic            flush_i,
    input  logic [XLEN-1:0] flush_pc_i,
    output logic            if_valid_o,
    output logic [XLEN-1:0] if_pc_o,
    output logic [XLEN-1:0] if_instr_o,
    input  logic            if_ready_i
);
    localparam int OW = $clog2(MAX_OUTSTANDING + 1);
    localparam int QW = $clog2(DEPTH) + 1;
    typedef logic [2*XLEN-1:0] entry_t;
    fetchq_state_e state, state_nx;
    logic [XLEN-1:0] fetch_pc, resp_pc, flush_tgt;
    logic [OW-1:0] outstanding, discard_cnt;
    logic [QW-1:0] occ;
    entry_t head, shown_q;
    logic gnt, keep, byp, push, pop;
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) state <= S_BOOT;
        else state <= state_nx;
    end
    always_comb state_nx = (state == S_BOOT) ? S_RUN : state;
    // Slots are reserved for every outstanding request, including ones that will be
    // discarded, so a response always finds room in the queue.
    always_comb begin
        ireq_o = (state == S_RUN) && !flush_i && (int'(occ) + int'(outstanding) < DEPTH)
                 && (int'(outstanding) < MAX_OUTSTANDING);
        iaddr_o = fetch_pc;
    end
    always_comb begin
        gnt = ireq_o && igrant_i;
        keep = irvalid_i && (discard_cnt == '0) && !flush_i;
`ifdef FETCHQ_BYPASS_EN
        byp = keep && (occ == '0);
`else
        byp = 1'b0;
`endif
        push = keep && !(byp && if_ready_i);
        pop = (occ != '0) && if_ready_i && !flush_i;
        flush_tgt = flush_pc_i & ~XLEN'(3);
        if_valid_o = byp || ((occ != '0) && !flush_i);
        {if_pc_o, if_instr_o} = byp ? {resp_pc, irdata_i} : (occ != '0) ? head : shown_q;
    end
    // shown_q remembers the last presented entry so the outputs hold when empty.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= '0;
            discard_cnt <= '0;
            shown_q     <= '0;
        end else begin
            outstanding <= outstanding + OW'(gnt) - OW'(irvalid_i);
            shown_q     <= {if_pc_o, if_instr_o};
            if (flush_i) begin
                fetch_pc    <= flush_tgt;
                resp_pc     <= flush_tgt;
                discard_cnt <= outstanding - OW'(irvalid_i);
            end else begin
                if (gnt) fetch_pc <= fetch_pc + XLEN'(4);
                if (keep) resp_pc <= resp_pc + XLEN'(4);
                if (irvalid_i && (discard_cnt != '0)) discard_cnt <= discard_cnt - OW'(1);
            end
        end
    end
    fetchq_fifo #(
        .DEPTH(DEPTH),
        .T    (entry_t)
    ) u_fifo (
        .clk_i  (clk_i),
        .reset_i(reset_i),
        .clr_i  (flush_i),
        .push_i (push),
        .din_i  ({resp_pc, irdata_i}),
        .pop_i  (pop),
        .dout_o (head),
        .occ_o  (occ)
    );
endmodule
